// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared definitions for the sequential divider.
//   - DIV_WIDTH_DEFAULT : default operand / result width
//   - div_state_e       : divider FSM state encoding
//   - cnt_width()       : step-counter width for a given operand width
package div_sequencer_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // clog2(width), kept at least one bit wide so a 1-bit divider still has a counter
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// div_step: one combinational unsigned restoring-division step.
// Ports:
//   rem_i      partial remainder entering the step (always < divisor)
//   dvd_bit_i  next dividend bit shifted in
//   divisor_i  divisor
//   rem_o      partial remainder leaving the step
//   q_bit_o    quotient bit produced by the step
module div_step
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift in the dividend bit, then trial-subtract the zero-extended divisor
    assign shifted = {rem_i, dvd_bit_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // A borrow (bit WIDTH set) means the divisor did not fit: keep the shifted value
    assign q_bit_o = ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: fixed-latency sequential unsigned divider (one bit per clock).
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        begin a division (ignored while busy)
//   dividend     dividend, sampled on the accepting edge
//   divisor      divisor, sampled on the accepting edge
//   busy         high while a division is in progress
//   done         one-cycle pulse when new results are valid
//   quotient     quotient of the last completed division
//   remainder    remainder of the last completed division
//   div_by_zero  last completed division had a zero divisor
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    // Dividend shifts out at the top while quotient bits fill in from the bottom
    logic [WIDTH-1:0] dvd_q,   dvd_d;
    logic [WIDTH-1:0] dsr_q,   dsr_d;
    logic [WIDTH-1:0] part_q,  part_d;
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dbz_q,   dbz_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] dvd_shifted;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (part_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // Drop the consumed dividend MSB and append the new quotient bit
    assign dvd_shifted = WIDTH'({dvd_q, step_qbit});

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            part_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            part_q  <= part_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        part_d  = part_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            RUN: begin
                busy_d = 1'b1;
                if (dsr_q == '0) begin
                    // Zero divisor: finish immediately with saturated quotient
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    part_d = step_rem;
                    dvd_d  = dvd_shifted;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                        quo_d   = dvd_shifted;
                        rem_d   = step_rem;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE
                if (start) begin
                    state_d = RUN;
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    part_d  = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand, quotient and remainder width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a division; sampled only while busy=0.
REQ-005 The module SHALL have ports dividend and divisor, input, WIDTH bits each: unsigned operands, sampled only on the accepting edge.
REQ-006 The module SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-007 The module SHALL have port done, output, 1 bit: single-cycle pulse marking the cycle in which new results are valid.
REQ-008 The module SHALL have ports quotient and remainder, output, WIDTH bits each: registered results of the most recent completed division.
REQ-009 The module SHALL have port div_by_zero, output, 1 bit: set with done when the latched divisor was zero; held until the next accepted start.

Function
REQ-010 The block SHALL be an FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, an edge with start=1 SHALL latch both operands, clear the step counter, clear div_by_zero, enter RUN, and set busy=1.
REQ-012 In IDLE or DONE, an edge with start=0 SHALL go to (or stay in) IDLE; DONE therefore lasts exactly one cycle.
REQ-013 In RUN, each edge SHALL perform one unsigned restoring step:
- Shift the (WIDTH+1)-bit partial remainder left, taking in the dividend MSB.
- Subtract the zero-extended divisor.
- If bit WIDTH of the result is 1, restore it and shift 0 into the quotient; otherwise shift 1 into the quotient.
REQ-014 The step counter SHALL run from 0 to WIDTH-1; the edge performing step WIDTH-1 SHALL enter DONE, load quotient and remainder, set done=1 and clear busy.
REQ-015 Latency SHALL be fixed: done is high in the cycle following the WIDTH-th edge after the accepting edge (16 cycles for WIDTH=16), independent of operand values.
REQ-016 A zero divisor latched on the accepting edge SHALL skip RUN: the next edge enters DONE with quotient all ones, remainder = dividend and div_by_zero=1.
REQ-017 start SHALL be ignored while busy=1; the operands in flight SHALL NOT change.
REQ-018 start=1 during the DONE cycle SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-019 quotient, remainder and div_by_zero SHALL change only on a completion edge (or div_by_zero clear on accept); they SHALL hold their values in IDLE and RUN.
REQ-020 done SHALL be high only in DONE; busy SHALL be high only in RUN.

Reset
REQ-021 On any rising edge with rst=1, the state SHALL become IDLE, with busy=0, done=0, div_by_zero=0, quotient=0, remainder=0 and the counter at 0.
REQ-022 rst SHALL take priority over start and over a division in progress; an aborted division SHALL produce no done pulse.

Structure
REQ-023 The FSM state encodings and the default WIDTH SHALL be placed in the shared processor package.
REQ-024 The single restoring step SHALL be a combinational sub-module, div_step (inputs: partial remainder, dividend bit, divisor; outputs: next remainder, quotient bit), instantiated once.
REQ-025 The counter width SHALL be clog2(WIDTH); no other arithmetic units SHALL be instantiated.

Verification
REQ-026 The bench SHALL cover: start with 100/7 -> done exactly 16 cycles after the accepting edge with quotient=14, remainder=2, div_by_zero=0.
REQ-027 The bench SHALL cover: 0xFFFF/0x8000 -> quotient=1, remainder=0x7FFF; then 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
REQ-028 The bench SHALL cover: 5/0 -> done one cycle after accept with quotient=0xFFFF, remainder=5, div_by_zero=1; the next accepted start clears div_by_zero.
REQ-029 The bench SHALL cover: start pulsed with 9/2 at step 5 of a 50/3 division -> the result stays 16/2 with no extra done pulse.
REQ-030 The bench SHALL cover: rst asserted at step 8 -> all outputs 0 on the next edge and no done pulse; then start in the DONE cycle (20/4 back-to-back) -> second done exactly 16 cycles later with quotient=5, remainder=0.
